// File: rtl/pc_sequencer_if.sv
// Control/handshake bundle between the sequencer and the datapath plus
// instruction/data memories.
interface pc_sequencer_if;
   logic       run;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic       dmem_ack;
   logic       zero;
   logic       comp;
   logic [7:0] jmp_target;
   logic [7:0] pc;
   logic       imem_req;
   logic [7:0] ir;
   logic       dmem_req;
   logic       dmem_we;
   logic       reg_we;
   logic       alu_src;
   logic       mem_to_reg;
   logic       halted;
   logic       fault;

   modport master (
      input  run, imem_ack, imem_data, dmem_ack, zero, comp, jmp_target,
      output pc, imem_req, ir, dmem_req, dmem_we, reg_we, alu_src,
             mem_to_reg, halted, fault
   );

   modport slave (
      output run, imem_ack, imem_data, dmem_ack, zero, comp, jmp_target,
      input  pc, imem_req, ir, dmem_req, dmem_we, reg_we, alu_src,
             mem_to_reg, halted, fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle control FSM for the 8-bit core: owns the PC, fetches over an
// ack handshake and sequences decode/exec/mem/writeback with a handshake timeout.
module pc_sequencer #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter int         ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   pc_sequencer_if.master    bus
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
   } state_t;

   localparam logic [2:0] OP_ALU   = 3'd0;
   localparam logic [2:0] OP_ADDI  = 3'd1;
   localparam logic [2:0] OP_LOAD  = 3'd2;
   localparam logic [2:0] OP_STORE = 3'd3;
   localparam logic [2:0] OP_BEQ   = 3'd4;
   localparam logic [2:0] OP_JUMP  = 3'd5;
   localparam logic [2:0] OP_BLT   = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

   state_t     state_reg;
   logic [7:0] pc_reg;
   logic [7:0] ir_reg;
   logic [7:0] cnt_reg;
   logic       fault_reg;

   logic [2:0] op;
   logic [7:0] pc_inc;
   logic [7:0] pc_branch;
   logic       timeout_hit;
   state_t     boundary_next;

   assign op          = ir_reg[7:5];
   assign pc_inc      = pc_reg + 8'd1;
   assign pc_branch   = pc_inc + {{3{ir_reg[4]}}, ir_reg[4:0]};
   assign timeout_hit = (cnt_reg + 8'd1) == TIMEOUT_VAL;
   // Every instruction boundary parks in IDLE when run is low.
   assign boundary_next = bus.run ? FETCH : IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         ir_reg    <= 8'h00;
         cnt_reg   <= 8'h00;
         fault_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= 8'h00;
               if (bus.run) state_reg <= FETCH;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  ir_reg    <= bus.imem_data;
                  cnt_reg   <= 8'h00;
                  state_reg <= DECODE;
               end else if (timeout_hit) begin
                  fault_reg <= 1'b1;
                  state_reg <= HALT;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            DECODE: begin
               cnt_reg   <= 8'h00;
               state_reg <= (op == OP_HALT) ? HALT : EXEC;
            end
            EXEC: begin
               case (op)
                  OP_ALU, OP_ADDI:  state_reg <= WB;
                  OP_LOAD, OP_STORE: state_reg <= MEM;
                  OP_BEQ: begin
                     pc_reg    <= bus.zero ? pc_branch : pc_inc;
                     state_reg <= boundary_next;
                  end
                  OP_BLT: begin
                     pc_reg    <= bus.comp ? pc_branch : pc_inc;
                     state_reg <= boundary_next;
                  end
                  OP_JUMP: begin
                     pc_reg    <= bus.jmp_target;
                     state_reg <= boundary_next;
                  end
                  default: state_reg <= HALT;
               endcase
            end
            MEM: begin
               if (bus.dmem_ack) begin
                  cnt_reg <= 8'h00;
                  if (op == OP_STORE) begin
                     pc_reg    <= pc_inc;
                     state_reg <= boundary_next;
                  end else begin
                     state_reg <= WB;
                  end
               end else if (timeout_hit) begin
                  fault_reg <= 1'b1;
                  state_reg <= HALT;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            WB: begin
               pc_reg    <= pc_inc;
               state_reg <= boundary_next;
            end
            HALT:    state_reg <= HALT;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Moore decode from state and the latched instruction only.
   assign bus.pc         = pc_reg;
   assign bus.ir         = ir_reg;
   assign bus.imem_req   = (state_reg == FETCH);
   assign bus.dmem_req   = (state_reg == MEM);
   assign bus.dmem_we    = (state_reg == MEM) && (op == OP_STORE);
   assign bus.reg_we     = (state_reg == WB);
   assign bus.alu_src    = (state_reg == EXEC) &&
                           ((op == OP_ADDI) || (op == OP_LOAD) || (op == OP_STORE));
   assign bus.mem_to_reg = (state_reg == WB) && (op == OP_LOAD);
   assign bus.halted     = (state_reg == HALT);
   assign bus.fault      = fault_reg;

endmodule
